// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard unit covering operand forwarding, load-use and branch stalls,
// and a data-memory wait FSM with timeout. Optional perf counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteEnE,
  input  logic        RegWriteEnM,
  input  logic        RegWriteEnW,
  input  logic        MemReadEnE,
  input  logic        MemReadEnM,
  input  logic        MemWriteEnM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        JalD,
  input  logic        DMemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MemErr,
  output logic [1:0]  State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_mem_err;

  logic               w_lw_stall;
  logic               w_br_stall;
  logic               w_mem_busy;
  logic               w_hazard;

  // Execute-stage operand select: M result has priority over W result.
  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] rs,
                                       input logic we_m, input logic [REG_W-1:0] rd_m,
                                       input logic we_w, input logic [REG_W-1:0] rd_w);
    if (we_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    w_lw_stall = MemReadEnE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    w_br_stall = BranchD &&
                 ((RegWriteEnE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D))) ||
                  (MemReadEnM  && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D))));
    w_mem_busy = (MemReadEnM || MemWriteEnM) && !DMemReadyM;
    w_hazard   = w_lw_stall || w_br_stall || w_mem_busy;
  end

  // Output decode; reset forces bubbles everywhere and no stalls or forwarding.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (rst) begin
      ForwardAE = fwd_e(Rs1E, RegWriteEnM, RdM, RegWriteEnW, RdW);
      ForwardBE = fwd_e(Rs2E, RegWriteEnM, RdM, RegWriteEnW, RdW);
      ForwardAD = RegWriteEnM && !MemReadEnM && (RdM != '0) && (RdM == Rs1D);
      ForwardBD = RegWriteEnM && !MemReadEnM && (RdM != '0) && (RdM == Rs2D);
      StallF    = w_hazard;
      StallD    = w_hazard;
      StallE    = w_mem_busy;
      StallM    = w_mem_busy;
      FlushW    = w_mem_busy;
      FlushE    = (w_lw_stall || w_br_stall) && !w_mem_busy;
      FlushD    = (PCSrcD || JalD) && !w_hazard;
      case (r_state)
        ST_MEM_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushD = 1'b0;
          FlushE = 1'b0;
          FlushW = !DMemReadyM;
        end
        ST_ERROR: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushD = 1'b0;
          FlushE = 1'b0;
          FlushW = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory wait FSM; ready wins over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_busy) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (DMemReadyM) begin
            r_state <= ST_RUN;
          end else if (r_wait_cnt == CNT_W'(MEM_WAIT_MAX)) begin
            r_state   <= ST_ERROR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_ERROR: r_mem_err <= 1'b1;
        default:  r_state   <= ST_RUN;
      endcase
    end
  end

  assign State  = r_state;
  assign MemErr = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PC_W = 32;

  logic [PC_W-1:0] r_stall_cnt;
  logic [PC_W-1:0] r_flush_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PC_W'(1);
      if ((FlushD || FlushE) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + PC_W'(1);
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus pushes model expectations, a negedge monitor compares.
`timescale 1ns/1ps
module tb_hazard_controller;

  localparam int unsigned WAIT_MAX = 4;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwe, rwm, rww, mre, mrm, mwm, br, pcs, jal, rdy;
  } in_t;

  typedef struct packed {
    logic [3:0] stall;   // F,D,E,M
    logic [2:0] flush;   // D,E,W
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic [1:0] state;
    logic       memerr;
    logic       rst_cyc;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic RegWriteEnE = 0, RegWriteEnM = 0, RegWriteEnW = 0;
  logic MemReadEnE = 0, MemReadEnM = 0, MemWriteEnM = 0;
  logic BranchD = 0, PCSrcD = 0, JalD = 0, DMemReadyM = 1;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE, State;
  logic ForwardAD, ForwardBD, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteEnE(RegWriteEnE), .RegWriteEnM(RegWriteEnM), .RegWriteEnW(RegWriteEnW),
    .MemReadEnE(MemReadEnE), .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JalD(JalD), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemErr(MemErr), .State(State)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: 0 running, 1 waiting on memory, 2 timed out.
  int   m_mode = 0;
  int   m_cnt  = 0;
  bit   m_err  = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
    end
  endfunction

  function automatic logic [1:0] exp_fwd_e(input in_t v, input logic [4:0] rs);
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input in_t v, input logic r, output out_t e);
    bit lw, br, busy, hz;
    e = '0;
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_err = 0;
      e.flush = 3'b111;
      e.rst_cyc = 1'b1;
      return;
    end
    e.fae = exp_fwd_e(v, v.rs1e);
    e.fbe = exp_fwd_e(v, v.rs2e);
    e.fad = v.rwm && !v.mrm && v.rdm != 0 && v.rdm == v.rs1d;
    e.fbd = v.rwm && !v.mrm && v.rdm != 0 && v.rdm == v.rs2d;
    lw   = v.mre && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d);
    br   = v.br && ((v.rwe && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d)) ||
                    (v.mrm && v.rdm != 0 && (v.rdm == v.rs1d || v.rdm == v.rs2d)));
    busy = (v.mrm || v.mwm) && !v.rdy;
    e.state  = 2'(m_mode);
    e.memerr = m_err;
    if (m_mode == 0) begin
      hz = lw || br || busy;
      e.stall = {hz, hz, busy, busy};
      e.flush = {(v.pcs || v.jal) && !hz, (lw || br) && !busy, busy};
      if (busy) begin m_mode = 1; m_cnt = 1; end
    end else if (m_mode == 1) begin
      e.stall = 4'hF;
      e.flush = {2'b00, !v.rdy};
      if (v.rdy) m_mode = 0;
      else if (m_cnt == int'(WAIT_MAX)) begin m_mode = 2; m_err = 1; end
      else m_cnt++;
    end else begin
      e.stall = 4'hF;
      e.flush = 3'b001;
    end
  endtask

  task automatic drive(input in_t v, input logic r);
    out_t e;
    @(posedge clk); #1;
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteEnE = v.rwe; RegWriteEnM = v.rwm; RegWriteEnW = v.rww;
    MemReadEnE = v.mre; MemReadEnM = v.mrm; MemWriteEnM = v.mwm;
    BranchD = v.br; PCSrcD = v.pcs; JalD = v.jal; DMemReadyM = v.rdy;
    rst = r;
    model_step(v, r, e);
    exp_q.push_back(e);
  endtask

  function automatic in_t idle();
    in_t v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
    v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
    v.rde  = 5'($urandom_range(0, 3)); v.rdm  = 5'($urandom_range(0, 3));
    v.rdw  = 5'($urandom_range(0, 3));
    v.rwe = 1'($urandom); v.rwm = 1'($urandom); v.rww = 1'($urandom);
    v.mre = 1'($urandom); v.br  = 1'($urandom); v.pcs = 1'($urandom);
    v.jal = ($urandom_range(0, 3) == 0);
    v.mrm = ($urandom_range(0, 3) == 0);
    v.mwm = ($urandom_range(0, 3) == 0);
    v.rdy = ($urandom_range(0, 3) != 0);
    return v;
  endfunction

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    out_t e;
`ifdef HAZARD_PERF_CNT_EN
    int m_scnt = 0;
    int m_fcnt = 0;
`endif
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",  32'({StallF, StallD, StallE, StallM}), 32'(e.stall));
        chk("flush",  32'({FlushD, FlushE, FlushW}), 32'(e.flush));
        chk("fwd_e",  32'({ForwardAE, ForwardBE}), 32'({e.fae, e.fbe}));
        chk("fwd_d",  32'({ForwardAD, ForwardBD}), 32'({e.fad, e.fbd}));
        chk("state",  32'(State), 32'(e.state));
        chk("memerr", 32'(MemErr), 32'(e.memerr));
`ifdef HAZARD_PERF_CNT_EN
        if (e.rst_cyc) begin m_scnt = 0; m_fcnt = 0; end
        chk("stall_cnt", StallCnt, 32'(m_scnt));
        chk("flush_cnt", FlushCnt, 32'(m_fcnt));
        if (!e.rst_cyc) begin
          m_scnt += int'(e.stall[3]);
          m_fcnt += int'(e.flush[2] | e.flush[1]);
        end
`endif
      end
    end
  end

  initial begin
    in_t v;
    logic r;
    repeat (3) drive(idle(), 1'b0);
    repeat (2) drive(idle(), 1'b1);

    // Load-use: stall + bubble, then load reaches W and forwards from there.
    v = idle(); v.mre = 1; v.rwe = 1; v.rde = 5; v.rs1d = 5; drive(v, 1'b1);
    v = idle(); v.mrm = 1; v.rwm = 1; v.rdm = 5; v.rs1d = 5; drive(v, 1'b1);
    v = idle(); v.rww = 1; v.rdw = 5; v.rs1e = 5; drive(v, 1'b1);

    // Forward priority on operand B.
    v = idle(); v.rwm = 1; v.rww = 1; v.rdm = 7; v.rdw = 7; v.rs2e = 7; drive(v, 1'b1);
    v.rdm = 0; drive(v, 1'b1);
    v.rdw = 0; drive(v, 1'b1);

    // Branch on an ALU result still in E, then forwarded from M.
    v = idle(); v.br = 1; v.pcs = 1; v.rwe = 1; v.rde = 3; v.rs2d = 3; drive(v, 1'b1);
    v = idle(); v.br = 1; v.pcs = 1; v.rwm = 1; v.rdm = 3; v.rs2d = 3; drive(v, 1'b1);
    v = idle(); v.jal = 1; drive(v, 1'b1);

    // Memory wait: ready low three cycles, then high.
    v = idle(); v.mrm = 1; v.rdy = 0;
    repeat (3) drive(v, 1'b1);
    v.rdy = 1; drive(v, 1'b1);
    drive(idle(), 1'b1);

    // Timeout into error, then reset recovers with no residual stall.
    v = idle(); v.mwm = 1; v.rdy = 0;
    repeat (7) drive(v, 1'b1);
    drive(v, 1'b0);
    drive(v, 1'b1);
    drive(idle(), 1'b1);

    // Ready coincident with the timeout count returns to run.
    v = idle(); v.mrm = 1; v.rdy = 0;
    repeat (4) drive(v, 1'b1);
    v.rdy = 1; drive(v, 1'b1);
    drive(idle(), 1'b1);

    // Reset asserted mid-wait.
    v = idle(); v.mrm = 1; v.rdy = 0;
    repeat (2) drive(v, 1'b1);
    drive(idle(), 1'b0);
    drive(idle(), 1'b1);

    // Randomized traffic with occasional resets (more likely once stuck in error).
    for (int i = 0; i < 800; i++) begin
      v = rand_in();
      r = 1'b1;
      if (m_mode == 2 && $urandom_range(0, 7) == 0) r = 1'b0;
      else if ($urandom_range(0, 99) < 2) r = 1'b0;
      drive(v, r);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
